// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback select, register file with two combinational read ports, commit counter.
// Define WB_BYPASS_EN to make a same-cycle write visible on the read ports.
module writeback_regfile #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       WB,
  input  logic [WIDTH-1:0] RD,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [4:0]       WriteReg,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic [WIDTH-1:0] WriteData,
  output logic [31:0]      WBCount
);
  localparam int AW = $clog2(NREGS);
  logic [WIDTH-1:0] regs [NREGS];
  logic [31:0] wb_count;
  logic commit;
  logic [WIDTH-1:0] stored1, stored2;
  assign WriteData = WB[1] ? RD : ALUResult;
  assign commit = WB[0] && (WriteReg != 5'd0);
  assign WBCount = wb_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wb_count <= '0;
    end else if (commit) begin
      regs[WriteReg[AW-1:0]] <= WriteData;
      wb_count <= wb_count + 32'd1;
    end
  end
  // r0 reads are forced to zero; it is never written
  assign stored1 = (ReadReg1 == 5'd0) ? '0 : regs[ReadReg1[AW-1:0]];
  assign stored2 = (ReadReg2 == 5'd0) ? '0 : regs[ReadReg2[AW-1:0]];
`ifdef WB_BYPASS_EN
  assign ReadData1 = rst ? '0 : (commit && ReadReg1 == WriteReg) ? WriteData : stored1;
  assign ReadData2 = rst ? '0 : (commit && ReadReg2 == WriteReg) ? WriteData : stored2;
`else
  assign ReadData1 = rst ? '0 : stored1;
  assign ReadData2 = rst ? '0 : stored2;
`endif
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed scoreboard bench for writeback_regfile.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] WB;
  logic [31:0] RD, ALUResult;
  logic [4:0] WriteReg, ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2, WriteData, WBCount;
  typedef struct {
    string tag;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];
  int ncmp = 0;
  int nfail = 0;
  writeback_regfile dut (
    .clk(clk), .rst(rst), .WB(WB), .RD(RD), .ALUResult(ALUResult),
    .WriteReg(WriteReg), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteData(WriteData), .WBCount(WBCount)
  );
  always #5 clk = ~clk;
  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic got(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    ncmp++;
    assert (obs === e.v) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] wb, input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd);
    WB = wb;
    WriteReg = wr;
    ALUResult = alu;
    RD = rd;
  endtask
  initial begin
    rst = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 32'h0);
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    tick();
    rst = 1'b0;
    #1;
    want("reset_count", 32'h0); got(WBCount);
    // reset clear
    drive(2'b01, 5'd5, 32'hDEADBEEF, 32'h0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 32'h0);
    ReadReg1 = 5'd5;
    #1;
    want("r5_written", 32'hDEADBEEF); got(ReadData1);
    want("count_1", 32'd1); got(WBCount);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    want("r5_cleared", 32'h0); got(ReadData1);
    want("count_cleared", 32'h0); got(WBCount);
    // writeback select and commit
    drive(2'b01, 5'd3, 32'h12345678, 32'hBADBAD00);
    #1;
    want("wd_alu", 32'h12345678); got(WriteData);
    tick();
    drive(2'b11, 5'd4, 32'h0BAD0BAD, 32'hCAFEF00D);
    #1;
    want("wd_mem", 32'hCAFEF00D); got(WriteData);
    tick();
    drive(2'b00, 5'd0, 32'h0, 32'h0);
    ReadReg1 = 5'd3;
    ReadReg2 = 5'd4;
    #1;
    want("r3", 32'h12345678); got(ReadData1);
    want("r4", 32'hCAFEF00D); got(ReadData2);
    want("count_2", 32'd2); got(WBCount);
    // r0 protection
    drive(2'b01, 5'd0, 32'hFFFFFFFF, 32'h0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 32'h0);
    ReadReg1 = 5'd0;
    #1;
    want("r0_zero", 32'h0); got(ReadData1);
    want("r0_count", 32'd2); got(WBCount);
    // RegWrite gating
    drive(2'b01, 5'd7, 32'h77, 32'h0);
    tick();
    drive(2'b00, 5'd7, 32'h55, 32'h0);
    ReadReg1 = 5'd7;
    #1;
    want("wd_nowrite", 32'h55); got(WriteData);
    tick();
    #1;
    want("r7_kept", 32'h77); got(ReadData1);
    want("gate_count", 32'd3); got(WBCount);
    // same-cycle hazard
    drive(2'b01, 5'd9, 32'h1, 32'h0);
    tick();
    drive(2'b01, 5'd9, 32'h2, 32'h0);
    ReadReg2 = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    want("hazard_same", 32'h2);
`else
    want("hazard_same", 32'h1);
`endif
    got(ReadData2);
    tick();
    drive(2'b00, 5'd0, 32'h0, 32'h0);
    #1;
    want("hazard_next", 32'h2); got(ReadData2);
    want("hazard_count", 32'd5); got(WBCount);
    // counter wrap: preload the counter directly
    force dut.wb_count = 32'hFFFFFFFF;
    #1;
    release dut.wb_count;
    drive(2'b01, 5'd10, 32'h3, 32'h0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 32'h0);
    ReadReg1 = 5'd10;
    #1;
    want("count_wrap", 32'h0); got(WBCount);
    want("r10", 32'h3); got(ReadData1);
    // reset priority over a simultaneous write
    rst = 1'b1;
    drive(2'b01, 5'd2, 32'hAA, 32'h0);
    ReadReg1 = 5'd2;
    #1;
    want("rd_during_rst", 32'h0); got(ReadData2);
    want("wd_during_rst", 32'hAA); got(WriteData);
    tick();
    rst = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 32'h0);
    #1;
    want("r2_dropped", 32'h0); got(ReadData1);
    want("r9_after_rst", 32'h0); got(ReadData2);
    want("rst_count", 32'h0); got(WBCount);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and register file for the pipelined CPU. It consumes the MEM/WB pipeline register's outputs, selects the writeback value (load data or ALU result), and commits it to a 32 x 32-bit register file. It also serves the two decode-stage read ports and keeps a committed-write counter for debug.

## Interface
Parameters:
- `NREGS`, default 32: number of architectural registers. Must be a power of two; address width is log2(NREGS).
- `WIDTH`, default 32: data width.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `WB`, input, 2: writeback control from MEM/WB. Bit 0 is RegWrite. Bit 1 is MemtoReg.
- `RD`, input, WIDTH: memory read data from MEM/WB.
- `ALUResult`, input, WIDTH: ALU result from MEM/WB.
- `WriteReg`, input, 5: destination register number from MEM/WB.
- `ReadReg1`, input, 5: decode read address, port 1.
- `ReadReg2`, input, 5: decode read address, port 2.
- `ReadData1`, output, WIDTH: read data, port 1 (combinational).
- `ReadData2`, output, WIDTH: read data, port 2 (combinational).
- `WriteData`, output, WIDTH: selected writeback value (combinational). Goes to the forwarding unit.
- `WBCount`, output, 32: number of committed register writes (registered).

## Operation
- Writeback select: `WriteData` is `RD` when MemtoReg is 1, otherwise `ALUResult`. This holds regardless of RegWrite.
- Commit: on a rising edge with `rst` = 0, RegWrite = 1 and `WriteReg` ≠ 0, the register at `WriteReg` receives `WriteData`.
- Register 0 is hardwired to 0:
  - Writes to it are discarded and do not increment `WBCount`.
  - Reads of it always return 0.
- Reads: `ReadDataN` returns the register addressed by `ReadRegN`. Both ports are independent and may address the same register.
- `WBCount` increments by 1 on each commit. It wraps from 0xFFFFFFFF to 0.
- Reset (`rst` = 1 at a rising edge):
  - All registers clear to 0.
  - `WBCount` clears to 0.
  - A write presented in the same cycle is dropped; reset has priority.
  - Reset mid-program takes effect at that edge. Reads in the following cycle return 0.
- If `WB` has an X or undefined state out of MEM/WB power-up, it is not a legal input. MEM/WB initialises to 0, so no write occurs.

## Timing
- Write latency: one edge. Data presented in cycle N is architecturally visible from cycle N+1.
- Read latency: combinational from `ReadRegN` and register state (zero cycles).
- `WriteData`: combinational from `WB[1]`, `RD` and `ALUResult`.
- `WBCount`: updates on the same edge as the commit it counts.
- Simultaneous write and read of the same nonzero register in cycle N:
  - Behaviour depends on the configuration below.
  - The new value is always visible from cycle N+1.
- Output values during and after reset:
  - `ReadData1` = 0 and `ReadData2` = 0.
  - `WBCount` = 0.
  - `WriteData` follows its inputs.

## Configuration
- `WB_BYPASS_EN` defined: internal write-through bypass.
  - If RegWrite = 1, `WriteReg` ≠ 0, `rst` = 0 and `ReadRegN` = `WriteReg`, then `ReadDataN` = `WriteData` in the same cycle.
  - This removes the need for a decode-stage stall on the WB→ID hazard.
- `WB_BYPASS_EN` undefined: `ReadDataN` returns the stored (old) value in that cycle. The hazard controller must insert one stall.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to r5, then assert `rst` for one cycle.
  - Required response: reading r5 returns 0 and `WBCount` = 0.
- Writeback select and commit:
  - Stimulus: WB = RegWrite 1 / MemtoReg 0 with `ALUResult` = 0x12345678 to r3. Next cycle, WB = RegWrite 1 / MemtoReg 1 with `RD` = 0xCAFEF00D to r4.
  - Required response: r3 = 0x12345678, r4 = 0xCAFEF00D, `WBCount` = 2.
- r0 protection:
  - Stimulus: write 0xFFFFFFFF to r0.
  - Required response: `ReadData1` with `ReadReg1` = 0 stays 0. `WBCount` is unchanged.
- RegWrite gating:
  - Stimulus: RegWrite 0, `WriteReg` = 7, `ALUResult` = 0x55.
  - Required response: r7 keeps its prior value. `WriteData` = 0x55. `WBCount` is unchanged.
- Same-cycle hazard:
  - Stimulus: r9 = 0x1 stored. Write 0x2 to r9 while `ReadReg2` = 9.
  - Required response in that cycle: `ReadData2` = 0x2 with `WB_BYPASS_EN`, 0x1 without it.
  - Required response next cycle: `ReadData2` = 0x2 in both builds.
- Counter wrap and reset priority:
  - Stimulus: preload `WBCount` to 0xFFFFFFFF, then commit one write.
  - Required response: `WBCount` = 0.
  - Stimulus: assert `rst` together with a write of 0xAA to r2.
  - Required response: r2 = 0.
